// File: rtl/timer_pkg.sv
// Shared constants for the iomem timer: register offsets, CTRL/STATUS bit
// positions and a byte-strobe merge helper.
package timer_pkg;

  localparam logic [7:0] TMR_CTRL   = 8'h00;
  localparam logic [7:0] TMR_PRESC  = 8'h04;
  localparam logic [7:0] TMR_COUNT  = 8'h08;
  localparam logic [7:0] TMR_CMP    = 8'h0C;
  localparam logic [7:0] TMR_STATUS = 8'h10;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_AUTORELOAD = 1;
  localparam int CTRL_ONESHOT    = 2;
  localparam int CTRL_MASK_MATCH = 3;
  localparam int CTRL_MASK_OVF   = 4;
  localparam int CTRL_W          = 5;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;
  localparam int STAT_W     = 2;

  // Replace only the bytes of old_val whose strobe bit is set.
  function automatic logic [31:0] wstrb_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/iomem_timer_presc.sv
// Prescaler: pcnt runs 0..presc while enabled and emits a one-cycle tick
// on the cycle where pcnt equals presc.
module iomem_timer_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] pcnt_q;
  logic [PRESC_W-1:0] pcnt_d;

  assign tick_o = en_i && (pcnt_q == presc_i);

  // Next pcnt: held at 0 when disabled or cleared, wraps to 0 on tick.
  always_comb begin
    pcnt_d = pcnt_q;
    if (!en_i || clr_i) begin
      pcnt_d = '0;
    end else if (tick_o) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESC_W'(1);
    end
  end

  // pcnt register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit timer/compare peripheral on the SoC iomem bus.
// Holds the register file, the bus handshake and the counter; the
// prescaler lives in iomem_timer_presc.
module iomem_timer
  import timer_pkg::*;
#(
  parameter logic [7:0] BASE_SEL = 8'h04,
  parameter int         PRESC_W  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
  logic [PRESC_W-1:0] presc_q,  presc_d;
  logic [31:0]        count_q,  count_d;
  logic [31:0]        cmp_q,    cmp_d;
  logic [STAT_W-1:0]  status_q, status_d;
  logic               ready_q;
  logic [31:0]        rdata_q,  rdata_d;

  logic        acc;
  logic        wr;
  logic [7:0]  off;
  logic [31:0] rd_val;
  logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic        tick;
  logic        unused_addr;

  // Address bits 23:8 are don't-care within the selected window.
  assign unused_addr = ^iomem_addr[23:8];

  assign off = iomem_addr[7:0];
  // A transaction is taken only in the idle cycle, so ready is a single pulse.
  assign acc = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_SEL);
  assign wr  = acc && (iomem_wstrb != 4'b0000);

  assign wr_ctrl   = wr && (off == TMR_CTRL);
  assign wr_presc  = wr && (off == TMR_PRESC);
  assign wr_count  = wr && (off == TMR_COUNT);
  assign wr_cmp    = wr && (off == TMR_CMP);
  assign wr_status = wr && (off == TMR_STATUS);

  iomem_timer_presc #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk     (clk),
    .reset   (reset),
    .en_i    (ctrl_q[CTRL_EN]),
    .clr_i   (wr_presc),
    .presc_i (presc_q),
    .tick_o  (tick)
  );

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_val = '0;
    case (off)
      TMR_CTRL:   rd_val[CTRL_W-1:0]  = ctrl_q;
      TMR_PRESC:  rd_val[PRESC_W-1:0] = presc_q;
      TMR_COUNT:  rd_val              = count_q;
      TMR_CMP:    rd_val              = cmp_q;
      TMR_STATUS: rd_val[STAT_W-1:0]  = status_q;
      default:    rd_val              = '0;
    endcase
  end

  assign rdata_d = acc ? rd_val : '0;

  // Next-state for the register file and counter; later statements override
  // earlier ones: W1C, then tick events (flag set beats clear), then bus writes.
  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    count_d  = count_q;
    cmp_d    = cmp_q;
    status_d = status_q;

    if (wr_status && iomem_wstrb[0]) begin
      status_d = status_q & ~iomem_wdata[STAT_W-1:0];
    end

    // A bus write to COUNT suppresses the whole tick evaluation.
    if (tick && !wr_count) begin
      if (count_q == cmp_q) begin
        status_d[STAT_MATCH] = 1'b1;
        count_d = ctrl_q[CTRL_AUTORELOAD] ? 32'd0 : count_q + 32'd1;
        if (ctrl_q[CTRL_ONESHOT]) ctrl_d[CTRL_EN] = 1'b0;
      end else begin
        count_d = count_q + 32'd1;
        if (count_q == 32'hFFFF_FFFF) status_d[STAT_OVF] = 1'b1;
      end
    end

    if (wr_ctrl && iomem_wstrb[0]) begin
      ctrl_d = iomem_wdata[CTRL_W-1:0];
    end
    if (wr_presc) begin
      for (int i = 0; i < PRESC_W; i++) begin
        if (iomem_wstrb[i/8]) presc_d[i] = iomem_wdata[i];
      end
    end
    if (wr_count) begin
      count_d = wstrb_merge(count_q, iomem_wdata, iomem_wstrb);
    end
    if (wr_cmp) begin
      cmp_d = wstrb_merge(cmp_q, iomem_wdata, iomem_wstrb);
    end
  end

  // Register file, counter and bus response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q   <= '0;
      presc_q  <= '0;
      count_q  <= '0;
      cmp_q    <= '0;
      status_q <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
      ready_q  <= acc;
      rdata_q  <= rdata_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq = |(status_q & ctrl_q[CTRL_MASK_OVF:CTRL_MASK_MATCH]);

endmodule
